// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx slave: bus op encodings, register map,
// receiver states and the divisor clamp.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      PINOOP = 2'd0,
      PIWROP = 2'd1,
      PIRDOP = 2'd2,
      PIRWOP = 2'd3
   } pi_op_e;

   localparam logic RXDATA   = 1'b0;
   localparam logic RXSTAT   = 1'b1;
   localparam int   VALIDBIT = 8;
   localparam int   OVRBIT   = 31;
   localparam int   FERRBIT  = 30;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

   // Very short bit periods cannot hold the mid-bit sampling point.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'd4) ? 16'd4 : d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// pi1r interconnect slave port as seen by uart_rx; the initiator drives
// op/addr/wdata/sel and the slave returns rdata/rdy/mapsz.
interface uart_rx_if #(
   parameter int ARCHBITSZ = 32
);
   localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);

   logic [1:0]             op;
   logic [ADDRBITSZ-1:0]   addr;
   logic [ARCHBITSZ-1:0]   wdata;
   logic [ARCHBITSZ-1:0]   rdata;
   logic [ARCHBITSZ/8-1:0] sel;
   logic                   rdy;
   logic [ARCHBITSZ-1:0]   mapsz;

   modport master (output op, addr, wdata, sel, input rdata, rdy, mapsz);
   modport slave  (input op, addr, wdata, sel, output rdata, rdy, mapsz);
endinterface

// File: rtl/uart_rx_fifo.sv
// BUFSZ x 8 synchronous byte FIFO; pop_data shows the head entry and is
// meaningful only while empty is low.
module uart_rx_fifo #(
   parameter int BUFSZ = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic [7:0]             pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(BUFSZ):0] count
);
   localparam int PW = $clog2(BUFSZ);

   logic [7:0]    mem [BUFSZ];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (PW + 1)'(BUFSZ));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   // A pop frees the slot a full FIFO needs for the simultaneous push.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and count alone decide
   // which entries are valid, so clearing the data would only cost logic.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver on the pi1r bus: synchronizer, bit-timing FSM, byte
// FIFO, and the RXDATA/RXSTAT register pair.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int ARCHBITSZ  = 32,
   parameter int BUFSZ      = 16,
   parameter int CLKSPERBIT = 868
) (
   input  logic     clk_i,
   input  logic     rst_i,
   uart_rx_if.slave pi1,
   input  logic     rx_i,
   output logic     intr_o
);
   localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
   localparam int CW        = $clog2(BUFSZ) + 1;

   logic                 sync1, sync2, rx_prev;
   logic [1:0]           settle;
   logic                 fall;
   rx_state_e            state;
   logic [15:0]          bit_cnt, cur_div, divisor;
   logic [2:0]           bit_idx;
   logic [7:0]           shreg, push_byte, fifo_data;
   logic                 push, ferr_evt, ovr, ferr;
   logic                 full, empty, pop, drop;
   logic [CW-1:0]        count;
   logic                 is_rd, is_wr, sel_stat, stat_rd;
   logic [ARCHBITSZ-1:0] rdata_q, data_word, status_word;
   logic                 unused_ok;

   // Edges are ignored until the chain holds real line samples, so a line
   // already low when reset releases never looks like a start bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         rx_prev <= 1'b1;
         settle  <= '0;
      end else begin
         sync1   <= rx_i;
         sync2   <= sync1;
         rx_prev <= sync2;
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   assign fall = (settle == 2'd3) && rx_prev && !sync2;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         cur_div   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         push      <= 1'b0;
         push_byte <= '0;
         ferr_evt  <= 1'b0;
      end else begin
         push     <= 1'b0;
         ferr_evt <= 1'b0;
         case (state)
            IDLE: if (fall) begin
               // The rate is frozen per frame so a divisor write never splits one.
               cur_div <= eff_div(divisor);
               bit_cnt <= eff_div(divisor) >> 1;
               state   <= START;
            end
            START: if (bit_cnt == '0) begin
               bit_cnt <= cur_div - 16'd1;
               bit_idx <= '0;
               state   <= sync2 ? IDLE : DATA;
            end else bit_cnt <= bit_cnt - 16'd1;
            DATA: if (bit_cnt == '0) begin
               shreg   <= {sync2, shreg[7:1]};
               bit_cnt <= cur_div - 16'd1;
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == 3'd7) state <= STOP;
            end else bit_cnt <= bit_cnt - 16'd1;
            STOP: if (bit_cnt == '0) begin
               push      <= sync2;
               push_byte <= shreg;
               ferr_evt  <= !sync2;
               state     <= IDLE;
            end else bit_cnt <= bit_cnt - 16'd1;
         endcase
      end
   end

   uart_rx_fifo #(.BUFSZ(BUFSZ)) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (push_byte),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign is_rd    = (pi1.op == PIRDOP) || (pi1.op == PIRWOP);
   assign is_wr    = (pi1.op == PIWROP) || (pi1.op == PIRWOP);
   assign sel_stat = (pi1.addr[0] == RXSTAT);
   assign pop      = is_rd && !sel_stat && !empty;
   assign stat_rd  = is_rd && sel_stat;
   assign drop     = push && full && !pop;

   // NOTE: every always_comb output gets a default first so no path through
   // the block leaves it unassigned and infers a latch.
   always_comb begin
      data_word   = '0;
      status_word = '0;
      if (!empty) begin
         data_word[VALIDBIT] = 1'b1;
         data_word[7:0]      = fifo_data;
      end
      status_word[OVRBIT]  = ovr;
      status_word[FERRBIT] = ferr;
      status_word[15:0]    = 16'(count);
   end

   // A flag event in the same cycle as a status read wins over the clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
         divisor <= 16'(CLKSPERBIT);
         ovr     <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         if (is_rd) rdata_q <= sel_stat ? status_word : data_word;
         if (is_wr && sel_stat) divisor <= pi1.wdata[15:0];
         ovr  <= (ovr && !stat_rd) || drop;
         ferr <= (ferr && !stat_rd) || ferr_evt;
      end
   end

   assign pi1.rdata = rdata_q;
   assign pi1.rdy   = 1'b1;
   assign pi1.mapsz = ARCHBITSZ'(2 * (ARCHBITSZ / 8));
   assign intr_o    = !empty;
   assign unused_ok = ^{pi1.sel, pi1.addr[ADDRBITSZ-1:1], pi1.wdata[ARCHBITSZ-1:16]};

endmodule
